// File: rtl/seven_seg_scan_controller.sv
// Multiplexed N-digit seven-segment driver: latched hex word, per-digit blank/dp,
// optional leading-zero suppression, registered pins that switch in lock-step.
module seven_seg_scan_controller #(
  parameter int NUM_DIGITS  = 8,
  parameter int SCAN_CYCLES = 100000,
  parameter bit ACTIVE_LOW  = 1'b1,
  parameter bit LZ_SUPPRESS = 1'b0,
  localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk_in,
  input  logic                    rst_in_n,
  input  logic [4*NUM_DIGITS-1:0] val_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load_in,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic [6:0]              cat_out,
  output logic                    dp_out,
  output logic [IDX_W-1:0]        digit_idx_out,
  output logic                    slot_done_out
);

  localparam int              CNT_W    = $clog2(SCAN_CYCLES);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SCAN_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  logic [4*NUM_DIGITS-1:0] val_q;
  logic [NUM_DIGITS-1:0]   blank_q;
  logic [NUM_DIGITS-1:0]   dp_q;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    run_q;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              cat_q, cat_d;
  logic                    dp_q_pin, dp_d_pin;
  logic [NUM_DIGITS-1:0]   lz_dark;

  function automatic logic [6:0] decode(input logic [3:0] nib);
    case (nib)
      4'h0: decode = 7'h3F;
      4'h1: decode = 7'h06;
      4'h2: decode = 7'h5B;
      4'h3: decode = 7'h4F;
      4'h4: decode = 7'h66;
      4'h5: decode = 7'h6D;
      4'h6: decode = 7'h7D;
      4'h7: decode = 7'h07;
      4'h8: decode = 7'h7F;
      4'h9: decode = 7'h6F;
      4'hA: decode = 7'h77;
      4'hB: decode = 7'h7C;
      4'hC: decode = 7'h39;
      4'hD: decode = 7'h5E;
      4'hE: decode = 7'h79;
      default: decode = 7'h71;
    endcase
  endfunction

  // A digit is a leading zero when it and every more significant nibble are zero.
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_lz
      if (gi == 0) begin : g_first
        assign lz_dark[gi] = 1'b0;
      end else begin : g_rest
        assign lz_dark[gi] = LZ_SUPPRESS && (val_q[4*NUM_DIGITS-1:4*gi] == '0);
      end
    end
  endgenerate

  // The counter holds for one cycle after reset while the pin register loads digit 0,
  // so the first slot is lit for the full SCAN_CYCLES.
  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (run_q) begin
      if (cnt_q == LAST_CNT) begin
        cnt_d = '0;
        idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    logic [3:0]            nib;
    logic                  dark;
    logic [6:0]            seg;
    logic                  dpv;
    logic [NUM_DIGITS-1:0] an_on;
    nib   = val_q[{idx_d, 2'b00} +: 4];
    dark  = blank_q[idx_d] | lz_dark[idx_d];
    seg   = dark ? 7'h00 : decode(nib);
    dpv   = ~blank_q[idx_d] & dp_q[idx_d];
    an_on = '0;
    an_on[idx_d] = 1'b1;
    an_d     = ACTIVE_LOW ? ~an_on : an_on;
    cat_d    = ACTIVE_LOW ? ~seg : seg;
    dp_d_pin = ACTIVE_LOW ? ~dpv : dpv;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in_n) begin
      val_q    <= '0;
      blank_q  <= '1;
      dp_q     <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      run_q    <= 1'b0;
      an_q     <= {NUM_DIGITS{ACTIVE_LOW}};
      cat_q    <= {7{ACTIVE_LOW}};
      dp_q_pin <= ACTIVE_LOW;
    end else begin
      run_q    <= 1'b1;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      an_q     <= an_d;
      cat_q    <= cat_d;
      dp_q_pin <= dp_d_pin;
      if (load_in) begin
        val_q   <= val_in;
        blank_q <= blank_in;
        dp_q    <= dp_in;
      end
    end
  end

  assign an_out        = an_q;
  assign cat_out       = cat_q;
  assign dp_out        = dp_q_pin;
  assign digit_idx_out = idx_q;
  assign slot_done_out = run_q && (cnt_q == LAST_CNT);

endmodule

// File: tb/tb_seven_seg_scan_controller.sv
// Directed bench: two active-low 8-digit instances (LZ off/on) and one
// active-high 4-digit instance, all with short scan slots.
module tb_seven_seg_scan_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] val;
  logic [7:0]  blank, dp;
  logic        load;
  logic [7:0]  an0, an1;
  logic [6:0]  cat0, cat1;
  logic        dp0, dp1, sd0, sd1;
  logic [2:0]  idx0, idx1;

  logic        rst2_n;
  logic [15:0] val2;
  logic [3:0]  blank2, dp2;
  logic        load2;
  logic [3:0]  an2;
  logic [6:0]  cat2;
  logic        dpo2, sd2;
  logic [1:0]  idx2;

  int n_cmp = 0;
  int n_err = 0;

  seven_seg_scan_controller #(.NUM_DIGITS(8), .SCAN_CYCLES(4), .ACTIVE_LOW(1'b1), .LZ_SUPPRESS(1'b0)) u0 (
    .clk_in(clk), .rst_in_n(rst_n), .val_in(val), .blank_in(blank), .dp_in(dp), .load_in(load),
    .an_out(an0), .cat_out(cat0), .dp_out(dp0), .digit_idx_out(idx0), .slot_done_out(sd0));

  seven_seg_scan_controller #(.NUM_DIGITS(8), .SCAN_CYCLES(4), .ACTIVE_LOW(1'b1), .LZ_SUPPRESS(1'b1)) u1 (
    .clk_in(clk), .rst_in_n(rst_n), .val_in(val), .blank_in(blank), .dp_in(dp), .load_in(load),
    .an_out(an1), .cat_out(cat1), .dp_out(dp1), .digit_idx_out(idx1), .slot_done_out(sd1));

  seven_seg_scan_controller #(.NUM_DIGITS(4), .SCAN_CYCLES(3), .ACTIVE_LOW(1'b0), .LZ_SUPPRESS(1'b0)) u2 (
    .clk_in(clk), .rst_in_n(rst2_n), .val_in(val2), .blank_in(blank2), .dp_in(dp2), .load_in(load2),
    .an_out(an2), .cat_out(cat2), .dp_out(dpo2), .digit_idx_out(idx2), .slot_done_out(sd2));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Hand-written gfedcba table, active-high.
  function automatic logic [6:0] seg_of(input logic [3:0] n);
    logic [6:0] t [16];
    t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
          7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    return t[n];
  endfunction

  function automatic logic [6:0] inv7(input logic [6:0] s);
    return ~s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idx(input int which, input int d);
    int n;
    int cur;
    n = 0;
    do begin
      tick();
      n++;
      cur = (which == 0) ? int'(idx0) : int'(idx2);
    end while (cur != d && n < 64);
    if (cur != d) check("wait_timeout", 32'(cur), 32'(d));
  endtask

  initial begin
    logic [7:0] an_exp;
    logic [3:0] an2_exp;
    logic [31:0] word;

    rst_n = 1'b0; val = '0; blank = '0; dp = '0; load = 1'b0;
    rst2_n = 1'b0; val2 = '0; blank2 = '0; dp2 = '0; load2 = 1'b0;
    tick(); tick();
    check("rst_an", 32'(an0), 32'hFF);
    check("rst_cat", 32'(cat0), 32'h7F);
    check("rst_dp", 32'(dp0), 32'h1);
    check("rst_idx", 32'(idx0), 32'h0);
    check("rst_sd", 32'(sd0), 32'h0);

    // Scan walk: 4 cycles per digit, full period 32.
    rst_n = 1'b1;
    for (int c = 0; c <= 32; c++) begin
      tick();
      an_exp = ~(8'h01 << ((c / 4) % 8));
      check($sformatf("scan_an_c%0d", c), 32'(an0), 32'(an_exp));
      if (c < 32) check($sformatf("scan_sd_c%0d", c), 32'(sd0), 32'((c % 4) == 3));
    end
    check("scan_blank_cat", 32'(cat0), 32'h7F);

    // Load timing: old shadow on the load edge, new data one edge later.
    val = 32'h0123_ABCD; blank = 8'h00; dp = 8'h00; load = 1'b1;
    tick();
    load = 1'b0;
    check("load_edge_cat", 32'(cat0), 32'h7F);
    tick();
    check("load_d0_cat", 32'(cat0), 32'(inv7(seg_of(4'hD))));
    word = 32'h0123_ABCD;
    for (int d = 1; d < 8; d++) begin
      wait_idx(0, d);
      check($sformatf("hex_d%0d_cat", d), 32'(cat0), 32'(inv7(seg_of(word[4*d +: 4]))));
    end
    check("lz_d7_zero_dark", 32'(cat1), 32'h7F);
    check("lz_d7_anode_on", 32'(an1), 32'h7F);

    val = 32'hFFFF_FFFF;
    wait_idx(0, 3);
    check("noload_d3_cat", 32'(cat0), 32'h08);
    check("noload_d3_an", 32'(an0), 32'hF7);

    // Leading-zero suppression.
    val = 32'h0000_00A0; load = 1'b1;
    tick();
    load = 1'b0;
    wait_idx(0, 0);
    check("lz_a0_d0", 32'(cat1), 32'(inv7(7'h3F)));
    wait_idx(0, 1);
    check("lz_a0_d1", 32'(cat1), 32'(inv7(7'h77)));
    for (int d = 2; d < 8; d++) begin
      wait_idx(0, d);
      check($sformatf("lz_a0_d%0d", d), 32'(cat1), 32'h7F);
      if (d == 2) check("nolz_a0_d2", 32'(cat0), 32'(inv7(7'h3F)));
    end
    val = 32'h0; dp = 8'h80; load = 1'b1;
    tick();
    load = 1'b0;
    wait_idx(0, 0);
    check("lz_zero_d0", 32'(cat1), 32'(inv7(7'h3F)));
    wait_idx(0, 4);
    check("lz_zero_d4", 32'(cat1), 32'h7F);
    wait_idx(0, 7);
    check("lz_zero_d7_cat", 32'(cat1), 32'h7F);
    check("lz_zero_d7_dp", 32'(dp1), 32'h0);

    // Blanking overrides decimal point.
    val = 32'h0123_ABCD; blank = 8'h02; dp = 8'h03; load = 1'b1;
    tick();
    load = 1'b0;
    wait_idx(0, 0);
    check("bl_d0_dp", 32'(dp0), 32'h0);
    check("bl_d0_cat", 32'(cat0), 32'(inv7(7'h5E)));
    wait_idx(0, 1);
    check("bl_d1_cat", 32'(cat0), 32'h7F);
    check("bl_d1_dp", 32'(dp0), 32'h1);
    check("bl_d1_an", 32'(an0), 32'hFD);
    wait_idx(0, 2);
    check("bl_d2_dp", 32'(dp0), 32'h1);

    // Reset mid-slot at digit 5, with a load strobe that must be ignored.
    wait_idx(0, 5);
    tick();
    rst_n = 1'b0; load = 1'b1; val = 32'hFFFF_FFFF; blank = 8'h00; dp = 8'hFF;
    tick();
    load = 1'b0;
    check("mrst_an", 32'(an0), 32'hFF);
    check("mrst_cat", 32'(cat0), 32'h7F);
    check("mrst_dp", 32'(dp0), 32'h1);
    check("mrst_idx", 32'(idx0), 32'h0);
    rst_n = 1'b1;
    for (int c = 0; c <= 4; c++) begin
      tick();
      check($sformatf("mrst_an_c%0d", c), 32'(an0), (c < 4) ? 32'hFE : 32'hFD);
      check($sformatf("mrst_cat_c%0d", c), 32'(cat0), 32'h7F);
      check($sformatf("mrst_dp_c%0d", c), 32'(dp0), 32'h1);
    end

    // Active-high, 4 digits, 3-cycle slots.
    check("ah_rst_an", 32'(an2), 32'h0);
    check("ah_rst_cat", 32'(cat2), 32'h0);
    check("ah_rst_dp", 32'(dpo2), 32'h0);
    rst2_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      an2_exp = 4'h1 << (c / 3);
      check($sformatf("ah_an_c%0d", c), 32'(an2), 32'(an2_exp));
      check($sformatf("ah_sd_c%0d", c), 32'(sd2), 32'((c % 3) == 2));
    end
    val2 = 16'h8000; blank2 = 4'h0; dp2 = 4'h1; load2 = 1'b1;
    tick();
    load2 = 1'b0;
    wait_idx(1, 3);
    check("ah_d3_cat", 32'(cat2), 32'h7F);
    check("ah_d3_an", 32'(an2), 32'h8);
    wait_idx(1, 0);
    check("ah_d0_cat", 32'(cat2), 32'h3F);
    check("ah_d0_dp", 32'(dpo2), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
